if_id_latch: RTL and testbench
==============================

IF_ID_LATCH -- requirements
Module: if_id_latch

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port instr_in, input, 16, instruction word from fetch.
REQ-004 SHALL have port pc_next_in, input, 16, PC+2 from fetch.
REQ-005 SHALL have port fetch_err, input, 1, fetch-stage error flag.
REQ-006 SHALL have port stall, input, 1, hold request from hazard logic.
REQ-007 SHALL have port flush, input, 1, squash request from branch/jump resolution.
REQ-008 SHALL have port instr_out, output, 16, registered instruction to decode.
REQ-009 SHALL have port pc_next_out, output, 16, registered PC+2 to decode/wb.
REQ-010 SHALL have port valid_out, output, 1, instr_out holds a real fetched instruction.
REQ-011 SHALL have port halted, output, 1, processor has drained after HALT.
REQ-012 SHALL have port err, output, 1, sticky error.
REQ-013 SHALL use constants NOP = 16'h0800 and HALT opcode = instr[15:11] == 5'b00000.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN, HALTED plus a 2-bit drain counter dcnt.
REQ-015 RUN, flush=1: instr_out <= NOP, valid_out <= 0, pc_next_out held; flush SHALL win over stall.
REQ-016 RUN, stall=1, flush=0: all registers SHALL hold.
REQ-017 RUN, no stall/flush: instr_out <= instr_in, pc_next_out <= pc_next_in, valid_out <= 1.
REQ-018 RUN capture of an instr_in with HALT opcode SHALL move to DRAIN with dcnt <= 0 in the same edge.
REQ-019 DRAIN: instr_in/pc_next_in SHALL be ignored; each non-stalled edge loads instr_out <= NOP, valid_out <= 0, dcnt <= dcnt+1.
REQ-020 DRAIN, stall=1: dcnt and outputs SHALL hold.
REQ-021 DRAIN, flush=1 (HALT squashed): SHALL return to RUN, instr_out <= NOP, valid_out <= 0, dcnt <= 0.
REQ-022 DRAIN with dcnt==3 on a non-stalled, non-flushed edge SHALL go to HALTED and set halted <= 1.
REQ-023 Latency: halted SHALL rise exactly 4 unstalled edges after the edge that loaded HALT into instr_out.
REQ-024 HALTED: all outputs SHALL hold, stall/flush/instr_in ignored; exit only via rst.
REQ-025 err SHALL set on any edge with fetch_err=1 (any state, not gated by stall) and stay set until rst.
REQ-026 dcnt SHALL never wrap; it is only reachable 0..3 in DRAIN.

Reset
REQ-027 rst=1 at an edge SHALL force state RUN, dcnt 0, instr_out NOP, pc_next_out 16'h0000, valid_out 0, halted 0, err 0, overriding all inputs.
REQ-028 rst mid-DRAIN or in HALTED SHALL abort immediately to reset values; first capture on the first edge with rst=0.

Verification
REQ-029 Reset then instr_in 16'h5810, pc_next_in 16'h0002, no stall -> next edge instr_out 16'h5810, pc_next_out 16'h0002, valid_out 1.
REQ-030 Stall and flush both 1 with instr_out 16'h5810 -> instr_out 16'h0800, valid_out 0.
REQ-031 Stall 3 cycles with instr_in changing -> instr_out/pc_next_out unchanged; release -> current instr_in captured next edge.
REQ-032 instr_in 16'h0000 captured at edge N, no stalls -> instr_out NOP from N+1, halted 0 through N+3, 1 at N+4 and held thereafter.
REQ-033 HALT captured, stall at N+2 for 2 cycles -> halted delayed to N+6; flush at N+2 instead -> RUN, halted stays 0, next instr captured.
REQ-034 fetch_err pulse 1 cycle during stall -> err 1 and held; rst -> err 0, instr_out 16'h0800.

Source files
------------

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch with stall/flush handling, HALT drain sequencing
// and a sticky fetch-error flag.
module if_id_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_next_in,
  input  logic        fetch_err,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_next_out,
  output logic        valid_out,
  output logic        halted,
  output logic        err
);

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [4:0]  HALT_OP = 5'b00000;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t      state, state_n;
  logic [1:0]  dcnt, dcnt_n;
  logic [15:0] instr_n, pc_n;
  logic        valid_n, halted_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      dcnt        <= 2'd0;
      instr_out   <= NOP;
      pc_next_out <= 16'h0000;
      valid_out   <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      instr_out   <= instr_n;
      pc_next_out <= pc_n;
      valid_out   <= valid_n;
      halted      <= halted_n;
      err         <= err | fetch_err;
    end
  end

  always_comb begin
    state_n  = state;
    dcnt_n   = dcnt;
    instr_n  = instr_out;
    pc_n     = pc_next_out;
    valid_n  = valid_out;
    halted_n = halted;
    unique case (state)
      RUN: begin
        if (flush) begin
          instr_n = NOP;
          valid_n = 1'b0;
        end else if (!stall) begin
          instr_n = instr_in;
          pc_n    = pc_next_in;
          valid_n = 1'b1;
          if (instr_in[15:11] == HALT_OP) begin
            state_n = DRAIN;
            dcnt_n  = 2'd0;
          end
        end
      end
      DRAIN: begin
        if (flush) begin
          state_n = RUN;
          dcnt_n  = 2'd0;
          instr_n = NOP;
          valid_n = 1'b0;
        end else if (!stall) begin
          instr_n = NOP;
          valid_n = 1'b0;
          // dcnt saturates at 3; the 4th drain edge halts instead
          if (dcnt == 2'd3) begin
            state_n  = HALTED;
            halted_n = 1'b1;
          end else begin
            dcnt_n = dcnt + 2'd1;
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_if_id_latch.sv
// Directed self-checking bench for if_id_latch.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_if_id_latch;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic [15:0] pc_next_in;
  logic        fetch_err;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc_next_out;
  logic        valid_out;
  logic        halted;
  logic        err;

  int n_cmp;
  int n_bad;

  if_id_latch dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .pc_next_in (pc_next_in),
    .fetch_err  (fetch_err),
    .stall      (stall),
    .flush      (flush),
    .instr_out  (instr_out),
    .pc_next_out(pc_next_out),
    .valid_out  (valid_out),
    .halted     (halted),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    instr_in   = 16'h0000;
    pc_next_in = 16'hFFFF;
    fetch_err  = 1'b1;
    stall      = 1'b1;
    flush      = 1'b1;
    tick();
    tick();
    fetch_err = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    n_cmp++;
    if (instr_out !== 16'h0800) begin
      n_bad++;
      $display("FAIL rst_instr got %h want 0800", instr_out);
    end
    n_cmp++;
    if (pc_next_out !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_pc got %h want 0000", pc_next_out);
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid got %b want 0", valid_out);
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_halted got %b want 0", halted);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err got %b want 0", err);
    end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    instr_in   = 16'h5810;
    pc_next_in = 16'h0002;
    tick();
    n_cmp++;
    if (instr_out !== 16'h5810) begin
      n_bad++;
      $display("FAIL cap_instr got %h want 5810", instr_out);
    end
    n_cmp++;
    if (pc_next_out !== 16'h0002) begin
      n_bad++;
      $display("FAIL cap_pc got %h want 0002", pc_next_out);
    end
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL cap_valid got %b want 1", valid_out);
    end
  endtask

  task automatic test_flush_stall();
    stall      = 1'b1;
    flush      = 1'b1;
    instr_in   = 16'h1111;
    pc_next_in = 16'h1234;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (instr_out !== 16'h0800) begin
      n_bad++;
      $display("FAIL fl_instr got %h want 0800", instr_out);
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_valid got %b want 0", valid_out);
    end
    n_cmp++;
    if (pc_next_out !== 16'h0002) begin
      n_bad++;
      $display("FAIL fl_pc got %h want 0002", pc_next_out);
    end
  endtask

  task automatic test_stall();
    instr_in   = 16'h6000;
    pc_next_in = 16'h0004;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in   = 16'h7100 + 16'(i);
      pc_next_in = 16'h0100 + 16'(i);
      tick();
      n_cmp++;
      if (instr_out !== 16'h6000 || pc_next_out !== 16'h0004 ||
          valid_out !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold%0d got %h/%h/%b want 6000/0004/1",
                 i, instr_out, pc_next_out, valid_out);
      end
    end
    stall      = 1'b0;
    instr_in   = 16'h7777;
    pc_next_in = 16'h0008;
    tick();
    n_cmp++;
    if (instr_out !== 16'h7777 || pc_next_out !== 16'h0008) begin
      n_bad++;
      $display("FAIL stall_release got %h/%h want 7777/0008",
               instr_out, pc_next_out);
    end
  endtask

  task automatic test_halt();
    instr_in   = 16'h0000;
    pc_next_in = 16'h000A;
    tick();
    n_cmp++;
    if (instr_out !== 16'h0000 || valid_out !== 1'b1 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_cap got %h/%b/%b want 0000/1/0",
               instr_out, valid_out, halted);
    end
    for (int i = 1; i <= 3; i++) begin
      instr_in   = 16'h5810 + 16'(i);
      pc_next_in = 16'h0200 + 16'(i);
      tick();
      n_cmp++;
      if (instr_out !== 16'h0800 || valid_out !== 1'b0 ||
          halted !== 1'b0 || pc_next_out !== 16'h000A) begin
        n_bad++;
        $display("FAIL halt_drain%0d got %h/%b/%b/%h want 0800/0/0/000A",
                 i, instr_out, valid_out, halted, pc_next_out);
      end
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_rise got %b want 1", halted);
    end
    for (int i = 0; i < 3; i++) begin
      stall    = i[0];
      flush    = ~i[0];
      instr_in = 16'h6000;
      tick();
      n_cmp++;
      if (halted !== 1'b1 || instr_out !== 16'h0800 ||
          valid_out !== 1'b0 || pc_next_out !== 16'h000A) begin
        n_bad++;
        $display("FAIL halt_hold%0d got %b/%h/%b/%h want 1/0800/0/000A",
                 i, halted, instr_out, valid_out, pc_next_out);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_halt_stall();
    do_reset();
    instr_in   = 16'h0000;
    pc_next_in = 16'h0020;
    tick();
    instr_in = 16'h1234;
    tick();
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL hstall_n5 got %b want 0", halted);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++;
      $display("FAIL hstall_n6 got %b want 1", halted);
    end
  endtask

  task automatic test_halt_flush();
    do_reset();
    instr_in   = 16'h0000;
    pc_next_in = 16'h0030;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (instr_out !== 16'h0800 || valid_out !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL hflush_sq got %h/%b/%b want 0800/0/0",
               instr_out, valid_out, halted);
    end
    instr_in   = 16'h5810;
    pc_next_in = 16'h0010;
    tick();
    n_cmp++;
    if (instr_out !== 16'h5810 || pc_next_out !== 16'h0010 ||
        valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL hflush_cap got %h/%h/%b want 5810/0010/1",
               instr_out, pc_next_out, valid_out);
    end
    instr_in = 16'h4000;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (halted !== 1'b0 || instr_out !== 16'h4000) begin
      n_bad++;
      $display("FAIL hflush_run got %b/%h want 0/4000", halted, instr_out);
    end
  endtask

  task automatic test_rst_drain();
    instr_in   = 16'h0000;
    pc_next_in = 16'h0040;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (instr_out !== 16'h0800 || pc_next_out !== 16'h0000 ||
        valid_out !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL rdrain_rst got %h/%h/%b/%b want 0800/0000/0/0",
               instr_out, pc_next_out, valid_out, halted);
    end
    instr_in   = 16'h3003;
    pc_next_in = 16'h0050;
    tick();
    n_cmp++;
    if (instr_out !== 16'h3003 || pc_next_out !== 16'h0050 ||
        valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL rdrain_cap got %h/%h/%b want 3003/0050/1",
               instr_out, pc_next_out, valid_out);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL rdrain_run got %b want 0", halted);
    end
  endtask

  task automatic test_err();
    stall     = 1'b1;
    fetch_err = 1'b1;
    instr_in  = 16'h2222;
    tick();
    fetch_err = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set got %b want 1", err);
    end
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b1 || instr_out !== 16'h3003) begin
      n_bad++;
      $display("FAIL err_hold got %b/%h want 1/3003", err, instr_out);
    end
    stall = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || instr_out !== 16'h0800) begin
      n_bad++;
      $display("FAIL err_rst got %b/%h want 0/0800", err, instr_out);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    instr_in   = 16'h0000;
    pc_next_in = 16'h0000;
    fetch_err  = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    test_reset();
    test_capture();
    test_flush_stall();
    test_stall();
    test_halt();
    test_halt_stall();
    test_halt_flush();
    test_rst_drain();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
